// File: rtl/pri_rv32_writeback_pkg.sv
// pri_rv32_writeback_pkg: shared constants for the RV32 write-back slice.
// Holds the datapath/index widths, load funct3 codes and the load FSM state encoding.
package pri_rv32_writeback_pkg;

   localparam int WB_DATA_W  = 32;
   localparam int WB_RADDR_W = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_LD_WAIT = 1'b1
   } wb_state_e;

endpackage

// File: rtl/pri_rv32_load_align.sv
// pri_rv32_load_align: combinational load data extraction and extension.
// Ports: i_rdata raw word, i_funct3 load type, i_addr_lo byte offset -> o_data extended value.
module pri_rv32_load_align
   import pri_rv32_writeback_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      unique case (i_addr_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   // Offset 1 takes the middle half; offset 3 has no full half left, so it
   // falls back to the upper half.
   always_comb begin
      w_half = i_rdata[15:0];
      unique case (i_addr_lo)
         2'd0: w_half = i_rdata[15:0];
         2'd1: w_half = i_rdata[23:8];
         default: w_half = i_rdata[31:16];
      endcase
   end

   // Reserved funct3 codes fall through to a full-word load.
   always_comb begin
      o_data = i_rdata;
      unique case (i_funct3)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  o_data = {24'h0, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LHU:  o_data = {16'h0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/pri_rv32_writeback.sv
// pri_rv32_writeback: RV32 write-back stage driving the register file write port.
// Ports: ex_* execute results (valid/ready), ld_* load issue/return and pending info,
// rf_* registered write port. Optional PRI_WB_MISALIGN_EN adds ld_misalign_o.
module pri_rv32_writeback
   import pri_rv32_writeback_pkg::*;
#(
   parameter int DATA_W  = WB_DATA_W,
   parameter int RADDR_W = WB_RADDR_W
)
(
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               ex_valid_i,
   output logic               ex_ready_o,
   input  logic               ex_we_i,
   input  logic [RADDR_W-1:0] ex_rd_i,
   input  logic [DATA_W-1:0]  ex_data_i,
   input  logic               ld_issue_i,
   output logic               ld_ready_o,
   input  logic [RADDR_W-1:0] ld_rd_i,
   input  logic [2:0]         ld_funct3_i,
   input  logic [1:0]         ld_addr_lo_i,
   input  logic               ld_rvalid_i,
   input  logic [DATA_W-1:0]  ld_rdata_i,
   output logic               ld_pending_o,
   output logic [RADDR_W-1:0] ld_pend_rd_o,
   output logic               rf_we_o,
   output logic [RADDR_W-1:0] rf_waddr_o,
   output logic [DATA_W-1:0]  rf_wdata_o
`ifdef PRI_WB_MISALIGN_EN
   ,
   output logic               ld_misalign_o
`endif
);

   wb_state_e          r_state;
   logic [RADDR_W-1:0] r_ld_rd;
   logic [2:0]         r_ld_f3;
   logic [1:0]         r_ld_lo;

   logic               r_sk_v;
   logic               r_sk_we;
   logic [RADDR_W-1:0] r_sk_rd;
   logic [DATA_W-1:0]  r_sk_data;

   logic               r_rf_we;
   logic [RADDR_W-1:0] r_rf_waddr;
   logic [DATA_W-1:0]  r_rf_wdata;

   logic               w_waw;
   logic               w_ex_xfer;
   logic               w_ex_wen;
   logic               w_ld_ret;
   logic               w_issue;
   logic [DATA_W-1:0]  w_ld_data;

   assign ld_pending_o = (r_state == ST_LD_WAIT);
   assign ld_ready_o   = (r_state == ST_IDLE);
   assign ld_pend_rd_o = r_ld_rd;

   // Holding back an ex write to the load's rd keeps the older load from
   // overwriting the younger result.
   assign w_waw = ld_pending_o & ex_we_i
                & (ex_rd_i == r_ld_rd) & (ex_rd_i != '0);
   assign ex_ready_o = ~r_sk_v & ~w_waw;
   assign w_ex_xfer  = ex_valid_i & ex_ready_o;
   assign w_ex_wen   = ex_we_i & (ex_rd_i != '0);
   assign w_ld_ret   = ld_pending_o & ld_rvalid_i;

`ifdef PRI_WB_MISALIGN_EN
   logic w_is_half;
   logic w_is_word;
   assign w_is_half = (ld_funct3_i == F3_LH) | (ld_funct3_i == F3_LHU);
   assign w_is_word = ~w_is_half
                    & (ld_funct3_i != F3_LB) & (ld_funct3_i != F3_LBU);
   assign ld_misalign_o = ld_issue_i
                        & ((w_is_half & ld_addr_lo_i[0])
                        |  (w_is_word & (ld_addr_lo_i != 2'd0)));
   assign w_issue = ld_ready_o & ld_issue_i & ~ld_misalign_o;
`else
   assign w_issue = ld_ready_o & ld_issue_i;
`endif

   pri_rv32_load_align u_align (
      .i_rdata   (ld_rdata_i),
      .i_funct3  (r_ld_f3),
      .i_addr_lo (r_ld_lo),
      .o_data    (w_ld_data)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ld_rd    <= '0;
         r_ld_f3    <= '0;
         r_ld_lo    <= '0;
         r_sk_v     <= 1'b0;
         r_sk_we    <= 1'b0;
         r_sk_rd    <= '0;
         r_sk_data  <= '0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state <= ST_LD_WAIT;
                  r_ld_rd <= ld_rd_i;
                  r_ld_f3 <= ld_funct3_i;
                  r_ld_lo <= ld_addr_lo_i;
               end
            end
            ST_LD_WAIT: begin
               if (ld_rvalid_i) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         r_rf_we <= 1'b0;
         if (w_ld_ret) begin
            r_rf_we    <= (r_ld_rd != '0);
            r_rf_waddr <= r_ld_rd;
            r_rf_wdata <= w_ld_data;
            // Colliding ex result parks in the skid for the next cycle.
            if (w_ex_xfer) begin
               r_sk_v    <= 1'b1;
               r_sk_we   <= w_ex_wen;
               r_sk_rd   <= ex_rd_i;
               r_sk_data <= ex_data_i;
            end
         end else if (r_sk_v) begin
            r_rf_we    <= r_sk_we;
            r_rf_waddr <= r_sk_rd;
            r_rf_wdata <= r_sk_data;
            r_sk_v     <= 1'b0;
         end else if (w_ex_xfer) begin
            r_rf_we    <= w_ex_wen;
            r_rf_waddr <= ex_rd_i;
            r_rf_wdata <= ex_data_i;
         end
      end
   end

   assign rf_we_o    = r_rf_we;
   assign rf_waddr_o = r_rf_waddr;
   assign rf_wdata_o = r_rf_wdata;

endmodule
